// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: two-digit BCD up-counter paced by an internal prescaler and
// controlled by start/stop/clear pulses; all outputs are registered.
module bcd_stopwatch #(
  parameter int TICK_DIV = 50000000,
  parameter int MOD      = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_ZERO = PW'(0);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] LAST_ONES = 4'((MOD - 1) % 10);
  localparam logic [3:0] LAST_TENS = 4'((MOD - 1) / 10);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [PW-1:0] pre_r;
  logic [PW-1:0] pre_s;
  logic          step_s;
  logic          last_s;
  logic [3:0]    ones_s;
  logic [3:0]    tens_s;
  logic          wrap_s;
  logic          running_s;

  // Next-state logic: clear beats stop, stop beats start.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, PAUSED: begin
          if (start && !stop) state_s = RUN;
          else                state_s = state_r;
        end
        RUN: begin
          if (stop) state_s = PAUSED;
          else      state_s = RUN;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Prescaler; it holds through a stop cycle so a resumed run keeps its partial step.
  always_comb begin
    pre_s  = pre_r;
    step_s = 1'b0;
    if (clear || state_r == IDLE) begin
      pre_s = PRE_ZERO;
    end else if (state_r == RUN && !stop) begin
      if (pre_r == PRE_LAST) begin
        pre_s  = PRE_ZERO;
        step_s = 1'b1;
      end else begin
        pre_s = pre_r + PRE_ONE;
      end
    end else begin
      pre_s = pre_r;
    end
  end

  // Digit update: modulus wrap first, then decade carry, then plain increment.
  always_comb begin
    last_s = (tens == LAST_TENS) && (ones == LAST_ONES);
    ones_s = ones;
    tens_s = tens;
    wrap_s = 1'b0;
    if (clear) begin
      ones_s = 4'd0;
      tens_s = 4'd0;
    end else if (step_s) begin
      if (last_s) begin
        ones_s = 4'd0;
        tens_s = 4'd0;
        wrap_s = 1'b1;
      end else if (ones == 4'd9) begin
        ones_s = 4'd0;
        tens_s = tens + 4'd1;
      end else begin
        ones_s = ones + 4'd1;
      end
    end else begin
      ones_s = ones;
      tens_s = tens;
    end
  end

  // Output decode from the next state so running is registered alongside it.
  always_comb begin
    running_s = (state_s == RUN);
  end

  // State, prescaler and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      pre_r   <= PRE_ZERO;
      ones    <= 4'd0;
      tens    <= 4'd0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_r <= state_s;
      pre_r   <= pre_s;
      ones    <= ones_s;
      tens    <= tens_s;
      running <= running_s;
      wrap    <= wrap_s;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: two instances (TICK_DIV=4/MOD=60 and
// TICK_DIV=2/MOD=13) against an arithmetic reference model, plus vectors and sequences.
module tb_bcd_stopwatch;

  localparam int TICK_A = 4;
  localparam int MOD_A  = 60;
  localparam int TICK_B = 2;
  localparam int MOD_B  = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] ones_a, tens_a, ones_b, tens_b;
  logic       running_a, wrap_a, running_b, wrap_b;

  int n_checks = 0;
  int n_fail   = 0;
  int wraps_a  = 0;
  int wraps_b  = 0;

  // Reference model state: running flag, count value, cycles accumulated toward a step.
  bit m_run[2];
  int m_cnt[2];
  int m_ph[2];
  bit m_wrap[2];

  typedef struct {
    logic       r, s, p, c;
    logic [3:0] o, t;
    logic       run, w;
  } vec_t;
  vec_t tbl[13];

  bcd_stopwatch #(.TICK_DIV(TICK_A), .MOD(MOD_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .ones(ones_a), .tens(tens_a), .running(running_a), .wrap(wrap_a)
  );

  bcd_stopwatch #(.TICK_DIV(TICK_B), .MOD(MOD_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .ones(ones_b), .tens(tens_b), .running(running_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  task automatic model_step(input int i, input int tick, input int modv,
                            input logic r, input logic s, input logic p, input logic c);
    m_wrap[i] = 1'b0;
    if (r || c) begin
      m_run[i] = 1'b0;
      m_cnt[i] = 0;
      m_ph[i]  = 0;
    end else if (m_run[i]) begin
      if (p) begin
        m_run[i] = 1'b0;
      end else begin
        m_ph[i] = m_ph[i] + 1;
        if (m_ph[i] == tick) begin
          m_ph[i]   = 0;
          m_wrap[i] = (m_cnt[i] == modv - 1);
          m_cnt[i]  = (m_cnt[i] + 1) % modv;
        end
      end
    end else if (s && !p) begin
      m_run[i] = 1'b1;
    end
  endtask

  task automatic check_dut(input int i, input int modv, input logic [3:0] o,
                           input logic [3:0] t, input logic run, input logic w);
    n_checks++;
    if (o !== 4'(m_cnt[i] % 10) || t !== 4'(m_cnt[i] / 10) ||
        run !== m_run[i] || w !== m_wrap[i]) begin
      n_fail++;
      $display("FAIL model_%0d @%0t: got tens=%0d ones=%0d running=%b wrap=%b, want tens=%0d ones=%0d running=%b wrap=%b",
               i, $time, t, o, run, w, m_cnt[i] / 10, m_cnt[i] % 10, m_run[i], m_wrap[i]);
    end
    n_checks++;
    if (o > 4'd9 || t > 4'd9 || (int'(t) * 10 + int'(o)) >= modv) begin
      n_fail++;
      $display("FAIL bcd_range_%0d @%0t: got tens=%0d ones=%0d, want BCD digits below %0d",
               i, $time, t, o, modv);
    end
  endtask

  task automatic expect_val(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, got, want);
    end
  endtask

  // One clock: drive inputs, advance model, sample DUTs 1 time unit after the edge.
  task automatic cycle(input logic r, input logic s, input logic p, input logic c);
    rst = r; start = s; stop = p; clear = c;
    @(posedge clk);
    model_step(0, TICK_A, MOD_A, r, s, p, c);
    model_step(1, TICK_B, MOD_B, r, s, p, c);
    #1;
    check_dut(0, MOD_A, ones_a, tens_a, running_a, wrap_a);
    check_dut(1, MOD_B, ones_b, tens_b, running_b, wrap_b);
    wraps_a += int'(wrap_a);
    wraps_b += int'(wrap_b);
  endtask

  initial begin
    // Vectors for instance A: reset, first step latency, start+stop, clear+start.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};

    for (int k = 0; k < 13; k++) begin
      cycle(tbl[k].r, tbl[k].s, tbl[k].p, tbl[k].c);
      n_checks++;
      if (ones_a !== tbl[k].o || tens_a !== tbl[k].t ||
          running_a !== tbl[k].run || wrap_a !== tbl[k].w) begin
        n_fail++;
        $display("FAIL vec_%0d: got tens=%0d ones=%0d running=%b wrap=%b, want tens=%0d ones=%0d running=%b wrap=%b",
                 k, tens_a, ones_a, running_a, wrap_a, tbl[k].t, tbl[k].o, tbl[k].run, tbl[k].w);
      end
    end

    // Basic count: first increment exactly 4 cycles after start, 10 after 40.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 3) expect_val("first_step_not_early", int'(ones_a), 0);
      if (k == 4) expect_val("first_step_on_time", int'(ones_a), 1);
    end
    expect_val("basic_tens", int'(tens_a), 1);
    expect_val("basic_ones", int'(ones_a), 0);
    expect_val("basic_running", int'(running_a), 1);

    // Full modulus run: A wraps once, B (MOD 13, 120 steps) wraps 9 times.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    wraps_a = 0;
    wraps_b = 0;
    for (int k = 1; k <= 240; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 236) expect_val("at_59", int'(tens_a) * 10 + int'(ones_a), 59);
    end
    expect_val("wrap_a_now", int'(wrap_a), 1);
    expect_val("wrap_a_count", wraps_a, 1);
    expect_val("wrap_b_count", wraps_b, 9);
    expect_val("b_value", int'(tens_b) * 10 + int'(ones_b), 3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("wrap_a_one_cycle", int'(wrap_a), 0);

    // Pause and resume: prescaler held at 2 across the pause.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    expect_val("pause_ones", int'(ones_a), 1);
    expect_val("pause_running", int'(running_a), 0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("pause_hold", int'(ones_a), 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("resume_not_yet", int'(ones_a), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("resume_step", int'(ones_a), 2);

    // Reset mid-run at 37, with start held high during reset.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (148) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("reach_37", int'(tens_a) * 10 + int'(ones_a), 37);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    expect_val("rst_value", int'(tens_a) * 10 + int'(ones_a), 0);
    expect_val("rst_running", int'(running_a), 0);
    expect_val("rst_wrap", int'(wrap_a), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("restart_ones", int'(ones_a), 1);

    // Random control pulses against the reference model.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
Two-digit BCD up-counting stopwatch that sits directly upstream of the BCD-to-7-segment decoders. It produces a units digit and a tens digit in BCD, one 4-bit value per decoder instance. Counting is paced by an internal prescaler and controlled by start, stop and clear pulses from the board keys. Key debouncing is done outside this block.

Parameters:
TICK_DIV, 50000000, clock cycles per count step; legal range 2..2^26.
MOD, 60, count modulus; the count runs 00..MOD-1 and then wraps. Legal range 2..100.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse; begin or resume counting.
stop  input  1  single-cycle pulse; pause counting.
clear  input  1  single-cycle pulse; zero the count and return to idle.
ones  output  4  BCD units digit (0..9); drives the units decoder.
tens  output  4  BCD tens digit (0..9); drives the tens decoder.
running  output  1  high while in state RUN.
wrap  output  1  one-cycle pulse on the step from MOD-1 to 00.

Behaviour:
- All outputs are registered. On reset: ones=0, tens=0, running=0, wrap=0, prescaler=0, state=IDLE.
- FSM states are IDLE, RUN and PAUSED.
- Control priority, highest first: rst > clear > stop > start.
- Transitions:
  - IDLE + start -> RUN; the prescaler is cleared to 0.
  - PAUSED + start -> RUN; the prescaler keeps its value, so the partial step is preserved.
  - RUN + stop -> PAUSED.
  - Any state + clear -> IDLE; digits and prescaler go to 0.
  - start while in RUN: ignored. stop while in IDLE or PAUSED: ignored.
- Simultaneous start and stop: stop wins. From RUN the next state is PAUSED; from IDLE or PAUSED the state is unchanged.
- clear in the same cycle as a step: clear wins. The result is 00 and wrap=0.
- Prescaler:
  - Width is clog2(TICK_DIV).
  - It increments only in RUN.
  - When it equals TICK_DIV-1 it returns to 0 and asserts an internal step in that same cycle.
- Step (occurs only in RUN, and only when no stop or clear is present that cycle):
  - If the value equals MOD-1 (tens*10+ones): ones=0, tens=0, and wrap=1 for one cycle.
  - Else if ones==9: ones=0 and tens=tens+1.
  - Else: ones=ones+1.
- Latency:
  - The new digit values appear on the clock edge that ends the step cycle.
  - From the start pulse in IDLE, the first increment is visible exactly TICK_DIV cycles after the start edge.
- Invariants: the digits never hold a non-BCD value (10..15), and the count never exceeds MOD-1.
- The running output equals (state==RUN), registered together with the state.
- wrap is 0 in every cycle other than the wrap step cycle.
- Reset asserted mid-count returns all outputs to their reset values on the next edge, regardless of the other inputs.

Test Plan:
1. Basic count (TICK_DIV=4, MOD=60): reset, start pulse, run 40 cycles -> ones=0, tens=1, running=1; the first increment occurs 4 cycles after start.
2. Decade carry and wrap: run from 00 for 59 steps -> 59; the next step gives 00 with wrap=1 for exactly 1 cycle, and wrap=0 everywhere else.
3. Pause and resume (TICK_DIV=4):
   - Start, wait 6 cycles, stop -> digits=1, running=0, value held for 20 cycles.
   - Start again -> the next increment arrives 2 cycles later, because the prescaler is retained.
4. Priority: start and stop asserted together in RUN -> PAUSED. Then clear together with start -> IDLE, 00, running=0.
5. Odd modulus (MOD=13, TICK_DIV=2): count 00..12 -> the step after 12 gives 00 with wrap=1. ones/tens never show values 10..15.
6. Reset mid-run at count 37 -> next edge gives 00, running=0, wrap=0. A later start counts again from 00.
